// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector.
//   - edge mode encodings (applied to all channels at once)
//   - default parameter values
//   - popcount helper used to total per-cycle pulses
package edge_det_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 1;
  localparam int DEF_CNT_W         = 8;

  // Widest pulse vector the popcount helper accepts; callers zero-extend.
  localparam int POP_MAX_W = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel of the edge detector: synchroniser, glitch filter,
// edge detector with mode select, and sticky flag.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   sig_async       raw asynchronous input bit
//   mode            edge select (rise / fall / both / off)
//   clear           sticky-flag clear (level)
//   pos_edge_o      registered pulse on every accepted rising transition
//   edge_o          registered pulse on transitions matching mode
//   sticky_o        latched edge_o, held until clear
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_async,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       pos_edge_o,
  output logic       edge_o,
  output logic       sticky_o
);

  localparam int FC_W = $clog2(FILTER_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   filt_q, filt_d;
  logic                   prev_q;
  logic [FC_W-1:0]        fcnt_q, fcnt_d;
  logic                   rise, fall;
  logic                   pos_q, pos_d;
  logic                   edge_q, edge_d;
  logic                   sticky_q, sticky_d;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // The counter only runs while the synchronised level disagrees with the
  // filtered level; the cycle it would hit FILTER_CYCLES the new level is
  // taken instead and the counter restarts from zero.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync_lvl != filt_q) begin
      if (fcnt_q == FC_W'(FILTER_CYCLES - 1)) begin
        filt_d = sync_lvl;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  assign rise = filt_q & ~prev_q;
  assign fall = ~filt_q & prev_q;

  always_comb begin
    pos_d = rise;
    case (mode)
      MODE_RISE: edge_d = rise;
      MODE_FALL: edge_d = fall;
      MODE_BOTH: edge_d = rise | fall;
      default:   edge_d = 1'b0;
    endcase
    // A new pulse beats a simultaneous clear so no event is lost.
    sticky_d = edge_q | (sticky_q & ~clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      filt_q   <= 1'b0;
      prev_q   <= 1'b0;
      fcnt_q   <= '0;
      pos_q    <= 1'b0;
      edge_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_async};
      filt_q   <= filt_d;
      prev_q   <= filt_q;
      fcnt_q   <= fcnt_d;
      pos_q    <= pos_d;
      edge_q   <= edge_d;
      sticky_q <= sticky_d;
    end
  end

  assign pos_edge_o = pos_q;
  assign edge_o     = edge_q;
  assign sticky_o   = sticky_q;

endmodule

// File: rtl/multi_edge_detector.sv
// WIDTH independent filtered edge detectors with a shared saturating
// event counter totalling all edge_out pulses.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   signal_in     asynchronous raw inputs, one per channel
//   mode          edge select for all channels
//   clear         per-channel sticky-flag clear
//   count_clr     clears event_count (pulses in the same cycle still count)
//   pos_edge_out  rising-edge pulses, independent of mode
//   edge_out      mode-selected edge pulses
//   sticky_out    per-channel latched edge_out
//   event_count   saturating total of edge_out pulses
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] signal_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clear,
  input  logic             count_clr,
  output logic [WIDTH-1:0] pos_edge_out,
  output logic [WIDTH-1:0] edge_out,
  output logic [WIDTH-1:0] sticky_out,
  output logic [CNT_W-1:0] event_count
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  // One spare bit above the worst case (max count + WIDTH) keeps the
  // saturation compare free of overflow.
  localparam int SUM_W = CNT_W + PC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sig_async (signal_in[i]),
      .mode      (mode),
      .clear     (clear[i]),
      .pos_edge_o(pos_edge_out[i]),
      .edge_o    (edge_out[i]),
      .sticky_o  (sticky_out[i])
    );
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] base;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;

  always_comb begin
    pc      = PC_W'(popcount(POP_MAX_W'(edge_out)));
    base    = count_clr ? '0 : count_q;
    sum     = SUM_W'(base) + SUM_W'(pc);
    count_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign event_count = count_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;
  import edge_det_pkg::*;

  localparam int W = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] signal_in;
  logic [1:0]   mode;
  logic [W-1:0] clear;
  logic         count_clr;

  logic [W-1:0] pos_a, edge_a, sticky_a;
  logic [W-1:0] pos_b, edge_b, sticky_b;
  logic [7:0]   cnt_a;
  logic [2:0]   cnt_b;

  // Instance a: defaults. Instance b: 4-cycle filter, 3-bit counter.
  multi_edge_detector #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode), .clear(clear),
    .count_clr(count_clr), .pos_edge_out(pos_a), .edge_out(edge_a),
    .sticky_out(sticky_a), .event_count(cnt_a));

  multi_edge_detector #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode), .clear(clear),
    .count_clr(count_clr), .pos_edge_out(pos_b), .edge_out(edge_b),
    .sticky_out(sticky_b), .event_count(cnt_b));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] o_pos[2], o_edge[2], o_sticky[2];
  int           o_cnt[2];
  assign o_pos[0] = pos_a;       assign o_pos[1] = pos_b;
  assign o_edge[0] = edge_a;     assign o_edge[1] = edge_b;
  assign o_sticky[0] = sticky_a; assign o_sticky[1] = sticky_b;
  assign o_cnt[0] = int'(cnt_a); assign o_cnt[1] = int'(cnt_b);

  // Reference model: input samples kept in a history queue; a filtered
  // level flips once the synchronised history has disagreed with it for
  // F consecutive samples; flips appear as pulses one edge later.
  int           F_of[2] = '{1, 4};
  int           MAXC[2] = '{255, 7};
  logic [W-1:0] hist[$];
  logic [W-1:0] m_filt[2], m_rise[2], m_fall[2];
  logic [W-1:0] e_pos[2], e_edge[2], e_sticky[2];
  int           e_cnt[2];

  task automatic model_step();
    logic [W-1:0] nxt_edge;
    logic [W-1:0] flip;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back('0);
      for (int k = 0; k < 2; k++) begin
        m_filt[k] = '0; m_rise[k] = '0; m_fall[k] = '0;
        e_pos[k] = '0; e_edge[k] = '0; e_sticky[k] = '0; e_cnt[k] = 0;
      end
      return;
    end
    hist.push_back(signal_in);
    if (hist.size() > 16) void'(hist.pop_front());
    for (int k = 0; k < 2; k++) begin
      case (mode)
        MODE_RISE: nxt_edge = m_rise[k];
        MODE_FALL: nxt_edge = m_fall[k];
        MODE_BOTH: nxt_edge = m_rise[k] | m_fall[k];
        default:   nxt_edge = '0;
      endcase
      e_sticky[k] = e_edge[k] | (e_sticky[k] & ~clear);
      e_cnt[k] = (count_clr ? 0 : e_cnt[k]) + $countones(e_edge[k]);
      if (e_cnt[k] > MAXC[k]) e_cnt[k] = MAXC[k];
      e_pos[k]  = m_rise[k];
      e_edge[k] = nxt_edge;
      for (int c = 0; c < W; c++) begin
        flip[c] = 1'b1;
        for (int j = 0; j < F_of[k]; j++)
          if (hist[hist.size() - 1 - S - j][c] == m_filt[k][c]) flip[c] = 1'b0;
      end
      m_rise[k] = flip & ~m_filt[k];
      m_fall[k] = flip & m_filt[k];
      m_filt[k] = m_filt[k] ^ flip;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    signal_in = '0;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_checks++;
      if ({pos_a, edge_a, sticky_a, cnt_a, pos_b, edge_b, sticky_b, cnt_b} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs t=%0d got=%h required=0", t,
                 {pos_a, edge_a, sticky_a, cnt_a, pos_b, edge_b, sticky_b, cnt_b});
      end
    end
  endtask

  task automatic test_rise_latency();
    mode = MODE_RISE;
    repeat (4) tick();
    signal_in[0] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      n_checks++;
      if (pos_a[0] !== (t == 3) || edge_a[0] !== (t == 3)) begin
        n_fail++;
        $display("FAIL latency_a t=%0d pos=%b edge=%b required=%b", t, pos_a[0], edge_a[0], t == 3);
      end
      n_checks++;
      if (pos_b[0] !== (t == 6)) begin
        n_fail++;
        $display("FAIL latency_b t=%0d pos=%b required=%b", t, pos_b[0], t == 6);
      end
    end
    n_checks++;
    if (sticky_a[0] !== 1'b1 || cnt_a !== 8'd1 || cnt_b !== 3'd1) begin
      n_fail++;
      $display("FAIL rise_after sticky=%b cnt_a=%0d cnt_b=%0d required 1/1/1", sticky_a[0], cnt_a, cnt_b);
    end
  endtask

  task automatic test_fall_mode();
    int n_pos_a = 0, n_edge_a = 0, n_edge_b = 0, n_edge_rise = 0;
    mode = MODE_FALL;
    signal_in[1] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      n_pos_a += int'(pos_a[1]);
      n_edge_rise += int'(edge_a[1]);
    end
    signal_in[1] = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      n_pos_a += int'(pos_a[1]);
      n_edge_a += int'(edge_a[1]);
      n_edge_b += int'(edge_b[1]);
    end
    n_checks++;
    if (n_edge_rise != 0 || n_edge_a != 1 || n_edge_b != 1) begin
      n_fail++;
      $display("FAIL fall_mode edge_on_rise=%0d edge_on_fall_a=%0d b=%0d required 0/1/1",
               n_edge_rise, n_edge_a, n_edge_b);
    end
    n_checks++;
    if (n_pos_a != 1) begin
      n_fail++;
      $display("FAIL fall_mode_pos got=%0d required=1", n_pos_a);
    end
    n_checks++;
    if (sticky_a[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_sticky_set got=%b required=1", sticky_a[1]);
    end
    clear[1] = 1'b1;
    tick();
    clear[1] = 1'b0;
    tick();
    n_checks++;
    if (sticky_a[1] !== 1'b0 || sticky_b[1] !== 1'b0 || sticky_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_clear a1=%b b1=%b a0=%b required 0/0/1", sticky_a[1], sticky_b[1], sticky_a[0]);
    end
  endtask

  task automatic test_glitch();
    int n_pos = 0, n_edge = 0;
    mode = MODE_RISE;
    signal_in[2] = 1'b1;
    repeat (2) tick();
    signal_in[2] = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      n_pos += int'(pos_b[2]);
    end
    n_checks++;
    if (n_pos != 0) begin
      n_fail++;
      $display("FAIL glitch_reject got=%0d required=0", n_pos);
    end
    signal_in[2] = 1'b1;
    repeat (6) tick();
    signal_in[2] = 1'b0;
    n_pos = 0;
    for (int t = 0; t < 14; t++) begin
      tick();
      n_pos += int'(pos_b[2]);
      n_edge += int'(edge_b[2]);
    end
    n_checks++;
    if (n_pos != 1 || n_edge != 1) begin
      n_fail++;
      $display("FAIL glitch_accept pos=%0d edge=%0d required 1/1", n_pos, n_edge);
    end
  endtask

  task automatic test_both_sat();
    bit seen;
    do_reset(2);
    mode = MODE_BOTH;
    signal_in = '0;
    repeat (10) tick();
    for (int i = 1; i <= 3; i++) begin
      signal_in = ~signal_in;
      repeat (10) tick();
      n_checks++;
      if (int'(cnt_a) != 4 * i || int'(cnt_b) != ((4 * i > 7) ? 7 : 4 * i)) begin
        n_fail++;
        $display("FAIL count_toggle i=%0d cnt_a=%0d cnt_b=%0d required %0d/%0d",
                 i, cnt_a, cnt_b, 4 * i, (4 * i > 7) ? 7 : 4 * i);
      end
    end
    signal_in = ~signal_in;
    seen = 0;
    for (int t = 0; t < 12 && !seen; t++) begin
      tick();
      if (edge_a == 4'hF) seen = 1;
    end
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    n_checks++;
    if (!seen || cnt_a !== 8'd4) begin
      n_fail++;
      $display("FAIL count_clr_a seen=%0d got=%0d required=4", seen, cnt_a);
    end
    seen = 0;
    for (int t = 0; t < 12 && !seen; t++) begin
      tick();
      if (edge_b == 4'hF) seen = 1;
    end
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    n_checks++;
    if (!seen || cnt_b !== 3'd4) begin
      n_fail++;
      $display("FAIL count_clr_b seen=%0d got=%0d required=4", seen, cnt_b);
    end
  endtask

  task automatic test_sticky_setclr();
    bit seen;
    mode = MODE_BOTH;
    repeat (10) tick();
    clear[3] = 1'b1;
    tick();
    clear[3] = 1'b0;
    signal_in[3] = ~signal_in[3];
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      tick();
      if (edge_a[3]) seen = 1;
    end
    tick();
    n_checks++;
    if (!seen || sticky_a[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_first seen=%0d got=%b required=1", seen, sticky_a[3]);
    end
    repeat (8) tick();
    signal_in[3] = ~signal_in[3];
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      tick();
      if (edge_a[3]) seen = 1;
    end
    clear[3] = 1'b1;
    tick();
    n_checks++;
    if (!seen || sticky_a[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set_wins seen=%0d got=%b required=1", seen, sticky_a[3]);
    end
    tick();
    n_checks++;
    if (sticky_a[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_held_clear got=%b required=0", sticky_a[3]);
    end
    clear[3] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n_pulse = 0;
    signal_in = '0;
    repeat (14) tick();
    signal_in[1] = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    signal_in[1] = 1'b0;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({pos_a, edge_a, sticky_a, cnt_a, pos_b, edge_b, sticky_b, cnt_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got=%h required=0",
               {pos_a, edge_a, sticky_a, cnt_a, pos_b, edge_b, sticky_b, cnt_b});
    end
    for (int t = 0; t < 12; t++) begin
      tick();
      n_pulse += $countones({pos_a, edge_a, pos_b, edge_b});
    end
    n_checks++;
    if (n_pulse != 0) begin
      n_fail++;
      $display("FAIL reset_mid_pulses got=%0d required=0", n_pulse);
    end
  endtask

  task automatic test_random();
    int hold[W];
    for (int c = 0; c < W; c++) hold[c] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < W; c++) begin
        if (hold[c] == 0) begin
          signal_in[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 8);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      clear     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      count_clr = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (o_pos[k] !== e_pos[k] || o_edge[k] !== e_edge[k]) begin
          n_fail++;
          $display("FAIL rand_pulse inst=%0d cyc=%0d pos=%b edge=%b required pos=%b edge=%b",
                   k, cyc, o_pos[k], o_edge[k], e_pos[k], e_edge[k]);
        end
        n_checks++;
        if (o_sticky[k] !== e_sticky[k] || o_cnt[k] != e_cnt[k]) begin
          n_fail++;
          $display("FAIL rand_state inst=%0d cyc=%0d sticky=%b cnt=%0d required sticky=%b cnt=%0d",
                   k, cyc, o_sticky[k], o_cnt[k], e_sticky[k], e_cnt[k]);
        end
      end
    end
    rst = 1'b0;
    clear = '0;
    count_clr = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    signal_in = '0;
    mode      = MODE_RISE;
    clear     = '0;
    count_clr = 1'b0;
    test_reset();
    test_rise_latency();
    test_fall_mode();
    test_glitch();
    test_both_sat();
    test_sticky_setclr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
